// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the stack_arbiter block.
// Optional feature macro: STACK_ARB_ERR_EN (see stack_arbiter.sv).
package stack_arb_pkg;

  // Sequencer states: accept, strobe the stack, let flags settle, respond.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Request opcodes as carried on req_op.
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: the winner is the first eligible index strictly
// after the pointer, wrapping modulo NREQ. Purely combinational.
module rr_arbiter
  import stack_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner
);

  // Walk ptr+1 .. ptr+NREQ and keep the first eligible hit.
  always_comb begin
    int  idx;
    logic found;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        winner      = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin sequencer sharing one stack between NREQ requesters.
// One transaction every 4 cycles: accept (T), strobe (T+1), settle (T+2),
// response (T+3).
// Optional feature macro: STACK_ARB_ERR_EN -- when defined, overflow pushes
// and underflow pops are granted, skip the stack strobe and respond with
// rsp_err=1; otherwise they are held back until the stack flags allow them.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [DW-1:0]      stk_data_in,
  input  logic [DW-1:0]      stk_data_out,
  input  logic               stk_ready,
  input  logic               stk_valid
);

  arb_state_e state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            op_q, op_d;
  logic            err_q, err_d;
  logic            stk_push_q, stk_push_d;
  logic            stk_pop_q, stk_pop_d;
  logic [DW-1:0]   stk_data_in_q, stk_data_in_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready_c;
  logic [IDW-1:0]  winner;
  logic            win_op;
  logic [DW-1:0]   win_data;
  logic            win_err;

  // Decide which pending requests the current stack flags allow through.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
`ifdef STACK_ARB_ERR_EN
      eligible[i] = req_valid[i];
`else
      eligible[i] = req_valid[i] &&
                    ((req_op[i] == OP_PUSH) ? stk_ready : stk_valid);
`endif
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .winner   (winner)
  );

  // Pick out the winning request's opcode/data and flag an error access.
  always_comb begin
    win_op   = req_op[winner];
    win_data = req_data[int'(winner)*DW +: DW];
`ifdef STACK_ARB_ERR_EN
    win_err  = (win_op == OP_PUSH) ? !stk_ready : !stk_valid;
`else
    win_err  = 1'b0;
`endif
  end

  // Next-state and next-output logic; strobes and responses default low.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    op_d          = op_q;
    err_d         = err_q;
    ready_c       = '0;
    stk_push_d    = 1'b0;
    stk_pop_d     = 1'b0;
    stk_data_in_d = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = '0;
    rsp_data_d    = '0;
    rsp_err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          ready_c    = grant;
          id_d       = winner;
          op_d       = win_op;
          err_d      = win_err;
          ptr_d      = winner;
          state_d    = ISSUE;
          stk_push_d = (win_op == OP_PUSH) && !win_err;
          stk_pop_d  = (win_op == OP_POP) && !win_err;
          if ((win_op == OP_PUSH) && !win_err) begin
            stk_data_in_d = win_data;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = err_q;
        if ((op_q == OP_POP) && !err_q) begin
          rsp_data_d = stk_data_out;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= IDW'(NREQ - 1);
      id_q          <= '0;
      op_q          <= OP_PUSH;
      err_q         <= 1'b0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      op_q          <= op_d;
      err_q         <= err_d;
      stk_push_q    <= stk_push_d;
      stk_pop_q     <= stk_pop_d;
      stk_data_in_q <= stk_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // req_ready is the only combinational output; hold it low while in reset.
  assign req_ready   = ready_c & {NREQ{rst_n}};
  assign stk_push    = stk_push_q;
  assign stk_pop     = stk_pop_q;
  assign stk_data_in = stk_data_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized self-checking bench for stack_arbiter (NREQ=4, stack SIZE=8).
// A transaction-level reference model (a queue for the stack, a round-robin
// pointer and the accept cycle of the current transaction) predicts every
// output each cycle. Build with +define+STACK_ARB_ERR_EN for the error mode.
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int SIZE = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_op = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               stk_push;
  logic               stk_pop;
  logic [DW-1:0]      stk_data_in;
  logic [DW-1:0]      stk_data_out = '0;
  logic               stk_ready;
  logic               stk_valid;

  always #5 clk = ~clk;

  stack_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_ready    (stk_ready),
    .stk_valid    (stk_valid)
  );

  // Behavioural stack the arbiter drives; not reset by rst_n.
  logic [DW-1:0] envMem [SIZE];
  int            envCnt = 0;

  always @(posedge clk) begin
    if (stk_push && envCnt < SIZE) begin
      envMem[envCnt] <= stk_data_in;
      envCnt         <= envCnt + 1;
    end else if (stk_pop && envCnt > 0) begin
      stk_data_out <= envMem[envCnt-1];
      envCnt       <= envCnt - 1;
    end
  end

  assign stk_ready = (envCnt < SIZE);
  assign stk_valid = (envCnt > 0);

  // Requester-side pending requests.
  bit            rv    [NREQ];
  bit            rop   [NREQ];
  logic [DW-1:0] rdata [NREQ];

  // Reference model state.
  int            vecCount = 0;
  int            missCount = 0;
  int            cyc = 0;
  bit            has = 0;
  int            ta = 0;
  int            tId = 0;
  bit            tOp = 0;
  bit            tErr = 0;
  logic [DW-1:0] tData = '0;
  logic [DW-1:0] tRdata = '0;
  int            ptr = NREQ - 1;
  logic [DW-1:0] refq [$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit eligibleModel(input int c);
`ifdef STACK_ARB_ERR_EN
    return rv[c];
`else
    return rv[c] && ((rop[c] == OP_PUSH) ? (refq.size() < SIZE) : (refq.size() > 0));
`endif
  endfunction

  function automatic bit anyPending();
    bit p = 0;
    for (int i = 0; i < NREQ; i++) p |= rv[i];
    return p;
  endfunction

  // One clock cycle: drive requests, predict and check every output, then
  // advance the model (accept, stack effect, pointer move).
  task automatic applyStimulus();
    int              w;
    int              d;
    logic [NREQ-1:0] expReady;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]            = rv[i];
      req_op[i]               = rop[i];
      req_data[i*DW +: DW]    = rdata[i];
    end
    #1;
    cyc++;
    d = cyc - ta;
    if (has && d >= 4) has = 0;
    checkOutput("stk_push", 64'(stk_push), 64'(has && d == 1 && tOp == OP_PUSH && !tErr));
    checkOutput("stk_pop", 64'(stk_pop), 64'(has && d == 1 && tOp == OP_POP && !tErr));
    if (has && d == 1)
      checkOutput("stk_data_in", 64'(stk_data_in), (tOp == OP_PUSH && !tErr) ? 64'(tData) : 64'd0);
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(has && d == 3));
    if (has && d == 3) begin
      checkOutput("rsp_id", 64'(rsp_id), 64'(tId));
      checkOutput("rsp_data", 64'(rsp_data), (tOp == OP_POP && !tErr) ? 64'(tRdata) : 64'd0);
      checkOutput("rsp_err", 64'(rsp_err), 64'(tErr));
    end
    expReady = '0;
    w = -1;
    if (!has) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (ptr + k) % NREQ;
        if (w < 0 && eligibleModel(c)) w = c;
      end
      if (w >= 0) expReady[w] = 1'b1;
    end
    checkOutput("req_ready", 64'(req_ready), 64'(expReady));
    if (w >= 0) begin
      has   = 1;
      ta    = cyc;
      tId   = w;
      tOp   = rop[w];
      tData = rdata[w];
      tErr  = (rop[w] == OP_PUSH) ? (refq.size() >= SIZE) : (refq.size() == 0);
      if (!tErr) begin
        if (tOp == OP_PUSH) refq.push_back(tData);
        else tRdata = refq.pop_back();
      end
      ptr   = w;
      rv[w] = 0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    checkOutput({tag, "_stk_push"}, 64'(stk_push), 64'd0);
    checkOutput({tag, "_stk_pop"}, 64'(stk_pop), 64'd0);
    checkOutput({tag, "_stk_data_in"}, 64'(stk_data_in), 64'd0);
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  task automatic resetModel();
    has = 0;
    ptr = NREQ - 1;
    refq.delete();
    for (int i = 0; i < envCnt; i++) refq.push_back(envMem[i]);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic assertReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkAllZero(tag);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    resetModel();
  endtask

  task automatic runUntilIdle(input int maxc);
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while ((has || anyPending()) && n < maxc);
    if (has || anyPending()) checkOutput("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic runUntilAccept(input int maxc);
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!(has && ta == cyc) && n < maxc);
    if (!(has && ta == cyc)) checkOutput("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic setReq(input int i, input bit op, input logic [DW-1:0] data);
    rv[i]    = 1;
    rop[i]   = op;
    rdata[i] = data;
  endtask

  initial begin
    int            cntBefore;
    int            popPct [3];
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 0; rop[i] = 0; rdata[i] = '0;
    end
    popPct[0] = 20; popPct[1] = 50; popPct[2] = 80;

    // Power-on reset with every requester asking to push.
    rst_n     = 1'b0;
    req_valid = '1;
    req_op    = '0;
    #11;
    checkAllZero("por");
    req_valid = '0;
    #1;
    rst_n = 1'b1;
    resetModel();

    // Push 0x11 then pop it back; the stack ends empty.
    setReq(0, OP_PUSH, 32'h11);
    runUntilIdle(20);
    setReq(1, OP_POP, 32'h0);
    runUntilIdle(20);
    checkOutput("stk_valid_after_pair", 64'(stk_valid), 64'd0);

    // Pop on an empty stack racing a push of 0x55.
    setReq(3, OP_POP, 32'h0);
    setReq(0, OP_PUSH, 32'h55);
    runUntilIdle(40);

    // Single push from requester 2.
    setReq(2, OP_PUSH, 32'hDEADBEEF);
    runUntilIdle(20);

    // Reset while a push strobe is on the stack interface.
    setReq(1, OP_PUSH, 32'hABCD);
    runUntilAccept(10);
    cntBefore = envCnt;
    applyStimulus();
    assertReset("rst_issue");
    runUntilIdle(10);
    checkOutput("abort_push_cnt", 64'(envCnt), 64'(cntBefore));

    // Reset while a pop waits for its data; no response may follow.
    if (envCnt == 0) begin
      setReq(0, OP_PUSH, 32'h77);
      runUntilIdle(20);
    end
    setReq(1, OP_POP, 32'h0);
    runUntilAccept(10);
    cntBefore = envCnt;
    applyStimulus();
    applyStimulus();
    assertReset("rst_wait");
    runUntilIdle(10);
    checkOutput("abort_pop_cnt", 64'(envCnt), 64'(cntBefore - 1));

    // Random traffic: push-heavy (fills the stack), mixed, pop-heavy.
    for (int p = 0; p < 3; p++) begin
      repeat (200) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!rv[i] && $urandom_range(0, 2) == 0) begin
            rop[i]   = ($urandom_range(0, 99) < popPct[p]) ? OP_POP : OP_PUSH;
            rdata[i] = $urandom;
            rv[i]    = 1;
          end
        end
        applyStimulus();
      end
      for (int i = 0; i < NREQ; i++) rv[i] = 0;
      runUntilIdle(10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `stack` instance between NREQ independent requesters.
- Each requester issues push or pop transactions. The block serialises them, drives the stack's push/pop/data_in strobes, and returns a tagged response (pop data or push acknowledge) to the winning requester.
- Sits directly in front of the `stack` module. Stack full/empty flags (ready/valid) gate which requests may proceed.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 32, data width; matches the stack data width.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request pending.
- req_op  in  NREQ  per-requester opcode; 0 = push, 1 = pop.
- req_data  in  NREQ*DW  per-requester push data; slice i = bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot accept pulse; request i is consumed when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  IDW  requester id the response belongs to.
- rsp_data  out  DW  popped word for a pop; 0 for a push.
- rsp_err  out  1  overflow/underflow error flag; constant 0 unless STACK_ARB_ERR_EN is defined.
- stk_push  out  1  push strobe to the stack.
- stk_pop  out  1  pop strobe to the stack.
- stk_data_in  out  DW  push data to the stack.
- stk_data_out  in  DW  stack output; valid the cycle after stk_pop.
- stk_ready  in  1  stack not full.
- stk_valid  in  1  stack not empty.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; the round-robin pointer is set to NREQ-1, so requester 0 has highest priority first.
  - All outputs are 0, including req_ready, stk_* strobes, rsp_*.
  - Any in-flight transaction is dropped; no response is produced for it.
- Eligibility: request i is eligible when req_valid[i] and either (req_op[i]=0 and stk_ready) or (req_op[i]=1 and stk_valid).
- FSM states and transitions:
  - IDLE: if any request is eligible, the winner w is the first eligible index searching upward from pointer+1, mod NREQ. req_ready[w]=1 combinationally this cycle. Latch id, op and data; pointer<=w; go to ISSUE. Otherwise stay in IDLE with req_ready=0.
  - ISSUE: exactly one of stk_push or stk_pop is 1 for this single cycle. stk_data_in = latched data on a push, 0 otherwise. Go to WAIT.
  - WAIT: stack flags settle. On a pop, capture stk_data_out into the rsp_data register at the end of this cycle. Go to RESP.
  - RESP: rsp_valid=1 for one cycle with rsp_id = latched id, rsp_data (0 for a push) and rsp_err. Go to IDLE.
- Latency: accept at cycle T, strobe at T+1, response at T+3. Maximum throughput is one transaction per 4 cycles.
- All outputs except req_ready are registered.
- Non-eligible requests (push while full, pop while empty) are skipped without being dropped. They remain pending and do not move the pointer.
- Simultaneous requests are resolved by round-robin only. A requester's op type gives it no priority.
- stk_push and stk_pop are never both 1 in the same cycle.
- Requesters must hold req_valid, req_op and req_data stable until accepted. Deasserting before acceptance is legal and simply withdraws the request.

Optional Feature:
- Macro: STACK_ARB_ERR_EN.
- When defined: an overflow push (stk_ready=0) or underflow pop (stk_valid=0) is eligible and granted normally. ISSUE asserts no stk_* strobe, and RESP returns rsp_err=1 with rsp_data=0.
- When undefined: such requests are masked as described under Behaviour, and rsp_err is tied to 0.

Decomposition:
- Package stack_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP) and opcode constants OP_PUSH=1'b0, OP_POP=1'b1.
- Sub-module rr_arbiter (NREQ): masked round-robin search. Inputs are the eligible vector and the pointer; outputs are the one-hot grant and the winner index.

Test Plan (NREQ=4, stack SIZE=8):
- Reset: hold rst_n=0 for 12 ns -> every output is 0. Assert rst_n again mid-run -> outputs clear asynchronously, before the next clock edge.
- Single push: req 2 pushes 0xDEADBEEF -> req_ready[2] at T; stk_push=1 with stk_data_in=0xDEADBEEF at T+1; rsp_valid at T+3 with rsp_id=2, rsp_data=0.
- Fairness: all 4 requesters push continuously -> accepts follow the order 0,1,2,3,0,... at 4-cycle spacing; 8 accepted pushes leave the stack full (stk_ready=0); further pushes get no req_ready.
- Push/pop pairing: req 0 pushes 0x11, then req 1 pops -> response with rsp_id=1, rsp_data=0x11; stk_valid=0 afterwards.
- Underflow, macro off: on an empty stack, req 3 pops and req 0 pushes 0x55 -> req 0 is granted first, then req 3 is granted and receives rsp_data=0x55.
- Underflow, macro on: req 3 pops an empty stack -> granted, no stk_pop, rsp_err=1, rsp_data=0.
- Reset during WAIT of a pop -> no rsp_valid after reset is released; the stack is untouched by the aborted transaction beyond the single strobe already issued.
